// File: rtl/bch_dec_ctrl_if.sv
// bch_dec_ctrl_if: serial input, decoder request/response and output handshake bundle (master = environment, slave = controller)
interface bch_dec_ctrl_if #(
  parameter int N = 63,
  parameter int K = 51
);
  logic         in_bit;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dec_codeword;
  logic         dec_start;
  logic [N-1:0] dec_result;
  logic         dec_done;
  logic [K-1:0] out_data;
  logic [2:0]   out_nerr;
  logic         out_fail;
  logic         out_valid;
  logic         out_ready;
  modport master (
    output in_bit, in_valid, dec_result, dec_done, out_ready,
    input  in_ready, dec_codeword, dec_start, out_data, out_nerr, out_fail, out_valid
  );
  modport slave (
    input  in_bit, in_valid, dec_result, dec_done, out_ready,
    output in_ready, dec_codeword, dec_start, out_data, out_nerr, out_fail, out_valid
  );
endinterface

// File: rtl/bch_dec_ctrl.sv
// bch_dec_ctrl: collects a serial N-bit codeword, runs one decoder request with timeout, returns K message bits (ports: clk, rst, bus = slave side of bch_dec_ctrl_if)
module bch_dec_ctrl #(
  parameter int N       = 63,
  parameter int K       = 51,
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst,
  bch_dec_ctrl_if.slave bus
);
  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] T_MAX  = 8'(TIMEOUT);
  typedef enum logic [1:0] {COLLECT, START, WAIT, OUTPUT} state_t;
  state_t state;
  logic [N-1:0] sreg;
  logic [BW-1:0] bcnt;
  logic [7:0] tcnt;
  logic [31:0] nerr_full;
  assign bus.in_ready = state == COLLECT;
  assign bus.dec_codeword = sreg;
  assign nerr_full = $countones(bus.dec_result ^ sreg);
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= COLLECT;
      sreg          <= '0;
      bcnt          <= '0;
      tcnt          <= '0;
      bus.dec_start <= 1'b0;
      bus.out_data  <= '0;
      bus.out_nerr  <= '0;
      bus.out_fail  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.dec_start <= 1'b0;
      case (state)
        COLLECT: if (bus.in_valid) begin
          sreg <= {sreg[N-2:0], bus.in_bit};
          if (bcnt == BIT_LAST) begin
            bcnt          <= '0;
            bus.dec_start <= 1'b1;
            state         <= START;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        START: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: if (bus.dec_done) begin
          bus.out_data  <= bus.dec_result[N-1:N-K];
          bus.out_nerr  <= nerr_full > 32'd7 ? 3'd7 : nerr_full[2:0];
          bus.out_fail  <= 1'b0;
          bus.out_valid <= 1'b1;
          state         <= OUTPUT;
        end else if (tcnt == T_LAST) begin
          tcnt          <= T_MAX;
          bus.out_data  <= sreg[N-1:N-K];
          bus.out_nerr  <= '0;
          bus.out_fail  <= 1'b1;
          bus.out_valid <= 1'b1;
          state         <= OUTPUT;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        OUTPUT: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          state         <= COLLECT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bch_dec_ctrl.sv
// tb_bch_dec_ctrl: randomized frames against a frame-timing reference model plus literal checks of the directed scenarios
module tb_bch_dec_ctrl;
  localparam int N  = 63;
  localparam int K  = 51;
  localparam int TO = 16;
  localparam logic [N-1:0] W =
    63'b0110111001_1110010001_1110000000_0110101010_0011100111_0110010111_100;
  localparam logic [K-1:0] TOP =
    51'b0110111001_1110010001_1110000000_0110101010_0011100111_0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bch_dec_ctrl_if #(.N(N), .K(K)) bus ();
  bch_dec_ctrl #(.N(N), .K(K), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int nt = 0;
  int nf = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nt++;
    if (got !== exp) begin
      nf++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask
  function automatic int popc(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction
  // decoder model: answers dec_start after dec_delay cycles (0 = never), optional spurious pulses outside a decode
  int dec_delay = 1;
  logic [N-1:0] fix_word = '0;
  bit spur = 1'b0;
  int cd = 0;
  initial begin
    bus.dec_done = 1'b0;
    bus.dec_result = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.dec_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.dec_done = 1'b1;
          bus.dec_result = fix_word;
        end
      end
      if (bus.dec_start && dec_delay > 0) cd = dec_delay;
      else if (spur && cd == 0 && !bus.dec_done && (bus.in_ready || bus.out_valid) && $urandom_range(0, 2) == 0) begin
        bus.dec_done = 1'b1;
        bus.dec_result = N'({$urandom(), $urandom()});
      end
    end
  end
  // reference model: frame-level timing (accept -> start next cycle, result one cycle after done
  // within TIMEOUT wait cycles, else failure after TIMEOUT) compared on every cycle
  bit mon_on = 1'b0;
  int cyc = 0;
  int nb = 0;
  bit busy = 1'b0;
  int t_start = -1;
  int t_out = 0;
  int p;
  bit ev;
  logic [N-1:0] sh = '0;
  logic [K-1:0] e_data = '0;
  logic [2:0] e_nerr = '0;
  logic e_fail = 1'b0;
  always @(negedge clk) if (mon_on) begin
    ev = busy && cyc >= t_out;
    chk("in_ready", bus.in_ready, !busy);
    chk("dec_start", bus.dec_start, cyc == t_start);
    chk("out_valid", bus.out_valid, ev);
    chk("dec_codeword", bus.dec_codeword, sh);
    if (ev) begin
      chk("out_data", bus.out_data, e_data);
      chk("out_nerr", bus.out_nerr, e_nerr);
      chk("out_fail", bus.out_fail, e_fail);
    end
    if (rst) begin
      sh = '0;
      nb = 0;
      busy = 1'b0;
      t_start = -1;
    end else if (!busy) begin
      if (bus.in_valid) begin
        sh = {sh[N-2:0], bus.in_bit};
        nb++;
        if (nb == N) begin
          nb = 0;
          busy = 1'b1;
          t_start = cyc + 1;
          t_out = cyc + 2 + TO;
          e_data = sh[N-1:N-K];
          e_nerr = '0;
          e_fail = 1'b1;
        end
      end
    end else if (cyc > t_start && cyc < t_out && bus.dec_done) begin
      t_out = cyc + 1;
      e_data = bus.dec_result[N-1:N-K];
      p = popc(bus.dec_result ^ sh);
      e_nerr = 3'(p > 7 ? 7 : p);
      e_fail = 1'b0;
    end else if (ev && bus.out_ready) begin
      busy = 1'b0;
    end
    cyc++;
  end
  task automatic send(input logic [N-1:0] w, input int cnt, input bit gap);
    for (int i = N - 1; i >= N - cnt; i--) begin
      int g;
      bit a;
      g = 0;
      bus.in_bit = w[i];
      do begin
        bus.in_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
        a = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
        g++;
      end while (!a && g < 1000);
      if (!a) chk("in_accept_wait", bus.in_ready, 1);
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic run(input logic [N-1:0] rx, input logic [N-1:0] fix, input int dly, input int hold,
                     input bit gap, output int lat, output logic [K-1:0] d, output logic [2:0] n, output logic f);
    dec_delay = dly;
    fix_word = fix;
    send(rx, N, gap);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) chk("out_valid_wait", bus.out_valid, 1);
    d = bus.out_data;
    n = bus.out_nerr;
    f = bus.out_fail;
    repeat (hold) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_bit = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", nt, nf);
    $fatal(1);
  end
  initial begin
    int lat;
    logic [K-1:0] d;
    logic [2:0] n;
    logic f;
    bus.in_bit = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_on = 1'b1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_dec_start", bus.dec_start, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_nerr", bus.out_nerr, 0);
    chk("rst_out_fail", bus.out_fail, 0);
    run(W, W, 1, 0, 1'b0, lat, d, n, f);
    chk("clean_latency", lat, 3);
    chk("clean_data", d, TOP);
    chk("clean_nerr", n, 0);
    chk("clean_fail", f, 0);
    run(W ^ (63'd1 << 5) ^ (63'd1 << 40), W, 1, 0, 1'b0, lat, d, n, f);
    chk("two_err_data", d, TOP);
    chk("two_err_nerr", n, 2);
    chk("two_err_fail", f, 0);
    run(W, W, 0, 0, 1'b0, lat, d, n, f);
    chk("timeout_latency", lat, 18);
    chk("timeout_data", d, TOP);
    chk("timeout_nerr", n, 0);
    chk("timeout_fail", f, 1);
    run(W ^ (63'd1 << 62), W, 16, 0, 1'b0, lat, d, n, f);
    chk("late_done_latency", lat, 18);
    chk("late_done_fail", f, 0);
    chk("late_done_nerr", n, 1);
    spur = 1'b1;
    run(W, W, 3, 10, 1'b0, lat, d, n, f);
    chk("backpressure_data", d, TOP);
    spur = 1'b0;
    send(W, 30, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    run(W, W, 2, 0, 1'b1, lat, d, n, f);
    chk("gapped_data", d, TOP);
    dec_delay = 0;
    send(W, N, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("wait_rst_out_valid", bus.out_valid, 0);
    for (int fr = 0; fr < 30; fr++) begin
      logic [N-1:0] w;
      logic [N-1:0] m;
      int ne;
      w = N'({$urandom(), $urandom()});
      m = '0;
      ne = int'($urandom_range(0, 9));
      for (int j = 0; j < ne; j++) m[$urandom_range(0, N - 1)] = 1'b1;
      spur = 1'($urandom_range(0, 1));
      run(w ^ m, w, int'($urandom_range(0, 20)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), lat, d, n, f);
    end
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule

// File: doc/bch_dec_ctrl.md
BCH_DEC_CTRL -- requirements
Module: bch_dec_ctrl

Interface
REQ-001 Parameter N, default 63: codeword length in bits.
REQ-002 Parameter K, default 51: message length in bits; message occupies codeword bits [N-1:N-K] (systematic, MSB first).
REQ-003 Parameter TIMEOUT, default 16: maximum cycles to wait for dec_done, range 1..255.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_bit  input  1  serial received codeword bit, MSB (bit N-1) first.
REQ-007 in_valid  input  1  in_bit valid.
REQ-008 in_ready  output  1  controller accepts in_bit this cycle.
REQ-009 dec_codeword  output  N  received codeword presented to the decoder.
REQ-010 dec_start  output  1  one-cycle pulse requesting a decode of dec_codeword.
REQ-011 dec_result  input  N  corrected codeword from the decoder.
REQ-012 dec_done  input  1  dec_result valid; sampled only in state WAIT.
REQ-013 out_data  output  K  corrected message bits.
REQ-014 out_nerr  output  3  count of bits corrected, saturating at 7.
REQ-015 out_fail  output  1  decoder timed out; out_data carries uncorrected message bits.
REQ-016 out_valid  output  1  out_data/out_nerr/out_fail valid.
REQ-017 out_ready  input  1  downstream accepts output.

Function
REQ-018 The FSM SHALL have states COLLECT, START, WAIT, OUTPUT.
REQ-019 In COLLECT, in_ready SHALL be 1; each cycle with in_valid=1 shifts in_bit into the LSB of a N-bit shift register and increments a bit counter.
REQ-020 When the N-th bit is accepted, the FSM SHALL move to START on the next cycle, with the counter cleared; in_ready SHALL be 0 in all other states.
REQ-021 In START, dec_start SHALL be 1 for exactly one cycle and the FSM SHALL enter WAIT with the timeout counter cleared.
REQ-022 dec_codeword SHALL equal the shift register at all times and SHALL remain stable from START until OUTPUT is exited.
REQ-023 In WAIT, if dec_done=1, the controller SHALL capture dec_result[N-1:N-K] into out_data, set out_nerr = min(popcount(dec_result XOR dec_codeword), 7), clear out_fail, and enter OUTPUT on the next cycle.
REQ-024 In WAIT, if dec_done=0 for TIMEOUT consecutive cycles, the controller SHALL load out_data from dec_codeword[N-1:N-K], set out_nerr=0 and out_fail=1, and enter OUTPUT.
REQ-025 dec_done on the same cycle as the timeout expiry SHALL take priority; the frame completes as a success.
REQ-026 dec_done in any state other than WAIT SHALL be ignored.
REQ-027 In OUTPUT, out_valid SHALL be 1, and out_data, out_nerr and out_fail SHALL be held stable until out_ready=1.
REQ-028 On out_valid & out_ready, the FSM SHALL return to COLLECT on the next cycle.
REQ-029 Minimum frame latency, from acceptance of the last input bit to out_valid, SHALL be 3 cycles when dec_done arrives on the first WAIT cycle.
REQ-030 A frame-level counter SHALL NOT wrap: the bit counter spans 0..N-1 only, and the timeout counter stops at TIMEOUT.
REQ-031 in_valid while in_ready=0 SHALL NOT alter the shift register.

Reset
REQ-032 While rst=1 at a clock edge, the FSM SHALL go to COLLECT and clear the counters and the shift register.
REQ-033 The same reset SHALL set out_data=0, out_nerr=0, out_fail=0, out_valid=0 and dec_start=0.
REQ-034 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-035 Reset asserted mid-frame, in any state, SHALL discard the partial or pending frame with no output produced.

Verification
REQ-036 Error-free frame: shift in 63'b011011100111100100011110000000011010101000111001110110010111100 with a decoder model returning the same word after 1 cycle -> out_data = the top 51 bits, out_nerr=0, out_fail=0, out_valid 3 cycles after the last bit.
REQ-037 Two-error frame: the same word with bits 5 and 40 flipped, and the model returning the corrected word -> out_data = the original top 51 bits, out_nerr=2.
REQ-038 Timeout: dec_done held 0 -> out_fail=1 and out_nerr=0 exactly 16 WAIT cycles after START, with out_data = the received top bits; repeat with dec_done on cycle 16 -> success.
REQ-039 Backpressure: out_ready=0 for 10 cycles -> out_valid and the output fields held stable, in_ready=0 throughout, and no dec_start issued; release -> COLLECT.
REQ-040 Gapped input: in_valid toggling randomly -> the frame is assembled correctly; rst mid-collection at bit 30 -> no output, and the next full frame decodes correctly.
REQ-041 Spurious dec_done during COLLECT and OUTPUT -> no state change and no output corruption.
